// File: rtl/alu_operand_pkg.sv
// rtl/alu_operand_pkg.sv - shared state encodings and immediate-mode constants for the operand stage
package alu_operand_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stage_state_t;

   localparam logic [1:0] IMM_SIGN  = 2'd0;
   localparam logic [1:0] IMM_ZERO  = 2'd1;
   localparam logic [1:0] IMM_UPPER = 2'd2;

endpackage

// File: rtl/operand_fwd_mux.sv
// rtl/operand_fwd_mux.sv - register-file / forwarding-source selector for one ALU operand
module operand_fwd_mux #(
   parameter int WIDTH = 32,
   parameter int N_FWD = 2,
   parameter int SEL_W = $clog2(N_FWD + 1)
) (
   input  logic [SEL_W-1:0]       i_sel,
   input  logic [WIDTH-1:0]       i_reg_data,
   input  logic [N_FWD*WIDTH-1:0] i_fwd_data,
   output logic [WIDTH-1:0]       o_data
);

   // Select values beyond N_FWD match no slice and keep the register-file value.
   always_comb begin
      o_data = i_reg_data;
      for (int k = 1; k <= N_FWD; k++) begin
         if (i_sel == SEL_W'(k)) begin
            o_data = i_fwd_data[(k-1)*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ALU operand select with two-entry skid buffer at the ID/EX boundary
module alu_operand_stage
   import alu_operand_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int IMM_WIDTH = 16,
   parameter int N_FWD     = 2,
   localparam int SEL_W    = $clog2(N_FWD + 1)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       read_data1,
   input  logic [WIDTH-1:0]       read_data2,
   input  logic [IMM_WIDTH-1:0]   immediate,
   input  logic [1:0]             imm_mode,
   input  logic                   alu_src,
   input  logic [SEL_W-1:0]       fwd_sel_a,
   input  logic [SEL_W-1:0]       fwd_sel_b,
   input  logic [N_FWD*WIDTH-1:0] fwd_data,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       operand_a,
   output logic [WIDTH-1:0]       operand_b
);

   localparam int EXT_W = WIDTH - IMM_WIDTH;

   stage_state_t     r_state;
   stage_state_t     w_next;
   logic             w_load_main;
   logic             w_main_from_skid;
   logic             w_load_skid;
   logic [WIDTH-1:0] w_fwd_a;
   logic [WIDTH-1:0] w_fwd_b;
   logic [WIDTH-1:0] w_ext;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] r_main_a;
   logic [WIDTH-1:0] r_main_b;
   logic [WIDTH-1:0] r_skid_a;
   logic [WIDTH-1:0] r_skid_b;

   operand_fwd_mux #(.WIDTH(WIDTH), .N_FWD(N_FWD), .SEL_W(SEL_W)) u_mux_a (
      .i_sel      (fwd_sel_a),
      .i_reg_data (read_data1),
      .i_fwd_data (fwd_data),
      .o_data     (w_fwd_a)
   );

   operand_fwd_mux #(.WIDTH(WIDTH), .N_FWD(N_FWD), .SEL_W(SEL_W)) u_mux_b (
      .i_sel      (fwd_sel_b),
      .i_reg_data (read_data2),
      .i_fwd_data (fwd_data),
      .o_data     (w_fwd_b)
   );

   always_comb begin
      case (imm_mode)
         IMM_ZERO:  w_ext = {{EXT_W{1'b0}}, immediate};
         IMM_UPPER: w_ext = {immediate, {EXT_W{1'b0}}};
         default:   w_ext = {{EXT_W{immediate[IMM_WIDTH-1]}}, immediate};
      endcase
      w_b = alu_src ? w_ext : w_fwd_b;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_next;
      end
   end

   // in_ready is 1 in EMPTY/ONE and out_valid is 1 in ONE/TWO, so in_valid
   // and out_ready alone stand for accept and consume inside each state.
   always_comb begin
      w_next           = r_state;
      w_load_main      = 1'b0;
      w_main_from_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush) begin
         w_next = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (in_valid) begin
                  w_next      = ONE;
                  w_load_main = 1'b1;
               end
            end
            ONE: begin
               if (in_valid && out_ready) begin
                  w_load_main = 1'b1;
               end else if (in_valid) begin
                  w_next      = TWO;
                  w_load_skid = 1'b1;
               end else if (out_ready) begin
                  w_next = EMPTY;
               end
            end
            TWO: begin
               if (out_ready) begin
                  w_next           = ONE;
                  w_main_from_skid = 1'b1;
               end
            end
            default: w_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_main_a <= '0;
         r_main_b <= '0;
         r_skid_a <= '0;
         r_skid_b <= '0;
      end else begin
         if (w_load_main) begin
            r_main_a <= w_fwd_a;
            r_main_b <= w_b;
         end else if (w_main_from_skid) begin
            r_main_a <= r_skid_a;
            r_main_b <= r_skid_b;
         end
         if (w_load_skid) begin
            r_skid_a <= w_fwd_a;
            r_skid_b <= w_b;
         end
      end
   end

   assign in_ready  = (r_state != TWO);
   assign out_valid = (r_state != EMPTY);
   assign operand_a = r_main_a;
   assign operand_b = r_main_b;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed self-checking bench for alu_operand_stage against a queue model
module tb_alu_operand_stage;

   localparam int W  = 32;
   localparam int IW = 16;
   localparam int NF = 2;
   localparam int SW = 2;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  read_data1;
   logic [W-1:0]  read_data2;
   logic [IW-1:0] immediate;
   logic [1:0]    imm_mode;
   logic          alu_src;
   logic [SW-1:0] fwd_sel_a;
   logic [SW-1:0] fwd_sel_b;
   logic [NF*W-1:0] fwd_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  operand_a;
   logic [W-1:0]  operand_b;

   int vectors    = 0;
   int miscompares = 0;
   bit check_en   = 1'b0;

   always #5 clock = ~clock;

   alu_operand_stage #(.WIDTH(W), .IMM_WIDTH(IW), .N_FWD(NF)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .read_data1 (read_data1),
      .read_data2 (read_data2),
      .immediate  (immediate),
      .imm_mode   (imm_mode),
      .alu_src    (alu_src),
      .fwd_sel_a  (fwd_sel_a),
      .fwd_sel_b  (fwd_sel_b),
      .fwd_data   (fwd_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .operand_a  (operand_a),
      .operand_b  (operand_b)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } pair_t;

   pair_t q[$];

   function automatic logic [W-1:0] m_ext(input logic [IW-1:0] imm, input logic [1:0] mode);
      logic [W-1:0] z;
      z = W'(imm);
      case (mode)
         2'd1:    return z;
         2'd2:    return z * 32'd65536;
         default: return W'($signed(imm));
      endcase
   endfunction

   function automatic logic [W-1:0] m_pick(input int sel, input logic [W-1:0] regv);
      if (sel < 1 || sel > NF) return regv;
      return fwd_data[(sel-1)*W +: W];
   endfunction

   always @(posedge clock or negedge reset_n) begin
      bit acc;
      bit con;
      pair_t p;
      if (!reset_n) begin
         q.delete();
      end else begin
         acc = in_valid && (q.size() < 2);
         con = out_ready && (q.size() > 0);
         p.a = m_pick(int'(fwd_sel_a), read_data1);
         p.b = alu_src ? m_ext(immediate, imm_mode) : m_pick(int'(fwd_sel_b), read_data2);
         if (flush) begin
            q.delete();
         end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(p);
         end
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n && check_en) begin
         check("model_out_valid", W'(out_valid), W'(q.size() > 0));
         check("model_in_ready", W'(in_ready), W'(q.size() < 2));
         if (q.size() > 0) begin
            check("model_operand_a", operand_a, q[0].a);
            check("model_operand_b", operand_b, q[0].b);
         end
      end
   end

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic drive(input logic [W-1:0] rd1, input logic [W-1:0] rd2, input logic [IW-1:0] imm,
                        input logic [1:0] mode, input logic src, input logic [SW-1:0] sa,
                        input logic [SW-1:0] sb);
      in_valid   = 1'b1;
      read_data1 = rd1;
      read_data2 = rd2;
      immediate  = imm;
      imm_mode   = mode;
      alu_src    = src;
      fwd_sel_a  = sa;
      fwd_sel_b  = sb;
   endtask

   initial begin
      reset_n    = 1'b0;
      in_valid   = 1'b0;
      read_data1 = '0;
      read_data2 = '0;
      immediate  = '0;
      imm_mode   = 2'd0;
      alu_src    = 1'b0;
      fwd_sel_a  = '0;
      fwd_sel_b  = '0;
      fwd_data   = {32'h0000BBBB, 32'h0000AAAA};
      flush      = 1'b0;
      out_ready  = 1'b1;
      #1;
      check("reset_out_valid", W'(out_valid), 32'd0);
      check("reset_in_ready", W'(in_ready), 32'd1);
      check("reset_operand_a", operand_a, 32'd0);
      check("reset_operand_b", operand_b, 32'd0);
      cyc();
      reset_n  = 1'b1;
      check_en = 1'b1;

      // sign-extended immediate
      drive(32'h5, 32'h9, 16'hFFFE, 2'd0, 1'b1, 2'd0, 2'd0);
      cyc();
      check("sign_out_valid", W'(out_valid), 32'd1);
      check("sign_a", operand_a, 32'h5);
      check("sign_b", operand_b, 32'hFFFFFFFE);
      drive(32'h6, 32'h9, 16'hFFFE, 2'd1, 1'b1, 2'd0, 2'd0);
      cyc();
      check("zero_b", operand_b, 32'h0000FFFE);
      drive(32'h7, 32'h9, 16'h1234, 2'd2, 1'b1, 2'd0, 2'd0);
      cyc();
      check("upper_b", operand_b, 32'h12340000);
      drive(32'h8, 32'h9, 16'h8001, 2'd3, 1'b1, 2'd2, 2'd1);
      cyc();
      check("reserved_b", operand_b, 32'hFFFF8001);
      check("fwd_a_imm", operand_a, 32'h0000BBBB);
      drive(32'h11, 32'h22, 16'h0, 2'd0, 1'b0, 2'd2, 2'd1);
      cyc();
      check("fwd_a", operand_a, 32'h0000BBBB);
      check("fwd_b", operand_b, 32'h0000AAAA);
      drive(32'h33, 32'h44, 16'h0, 2'd0, 1'b0, 2'd3, 2'd0);
      cyc();
      check("illegal_sel_a", operand_a, 32'h33);
      check("reg_b", operand_b, 32'h44);
      in_valid = 1'b0;
      cyc();
      check("drain_out_valid", W'(out_valid), 32'd0);

      // backpressure fills both entries, then drains in order
      out_ready = 1'b0;
      drive(32'hA1, 32'hB1, 16'h0, 2'd0, 1'b0, 2'd0, 2'd0);
      cyc();
      drive(32'hA2, 32'hB2, 16'h0, 2'd0, 1'b0, 2'd0, 2'd0);
      cyc();
      drive(32'hA3, 32'hB3, 16'h0, 2'd0, 1'b0, 2'd0, 2'd0);
      cyc();
      in_valid = 1'b0;
      check("full_in_ready", W'(in_ready), 32'd0);
      check("hold_p1_a", operand_a, 32'hA1);
      out_ready = 1'b1;
      cyc();
      check("drain_p2_a", operand_a, 32'hA2);
      check("drain_in_ready", W'(in_ready), 32'd1);
      cyc();
      check("drain_done", W'(out_valid), 32'd0);

      // flush while full drops the buffer and the concurrent request
      out_ready = 1'b0;
      drive(32'hC1, 32'hD1, 16'h0, 2'd0, 1'b0, 2'd0, 2'd0);
      cyc();
      drive(32'hC2, 32'hD2, 16'h0, 2'd0, 1'b0, 2'd0, 2'd0);
      cyc();
      drive(32'hC3, 32'hD3, 16'h0, 2'd0, 1'b0, 2'd0, 2'd0);
      flush = 1'b1;
      cyc();
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("flush_out_valid", W'(out_valid), 32'd0);
      check("flush_in_ready", W'(in_ready), 32'd1);
      repeat (3) cyc();

      // full-rate stream with random data
      for (int i = 0; i < 8; i++) begin
         fwd_data = {$urandom(), $urandom()};
         drive($urandom(), $urandom(), 16'($urandom()), 2'($urandom()), 1'($urandom()),
               2'($urandom()), 2'($urandom()));
         out_ready = (i % 3) != 2;
         cyc();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) cyc();

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      drive(32'hE1, 32'hF1, 16'h0, 2'd0, 1'b0, 2'd0, 2'd0);
      cyc();
      drive(32'hE2, 32'hF2, 16'h0, 2'd0, 1'b0, 2'd0, 2'd0);
      cyc();
      #1;
      reset_n = 1'b0;
      #1;
      check("async_out_valid", W'(out_valid), 32'd0);
      check("async_in_ready", W'(in_ready), 32'd1);
      check("async_operand_a", operand_a, 32'd0);
      check("async_operand_b", operand_b, 32'd0);
      #1;
      reset_n = 1'b1;
      drive(32'h77, 32'h88, 16'h0, 2'd0, 1'b0, 2'd0, 2'd0);
      cyc();
      in_valid = 1'b0;
      check("post_reset_valid", W'(out_valid), 32'd1);
      check("post_reset_a", operand_a, 32'h77);
      out_ready = 1'b1;
      repeat (2) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
